// File: rtl/udp_tx_arb_if.sv
// udp_tx_arb_if: source-side and UDP-side stream bundle for udp_tx_arb.
// master = application/stack side driving requests; slave = the arbiter.
`timescale 1ns/1ps
interface udp_tx_arb_if #(
  parameter int NUM_SRC = 4,
  parameter int PORT_W  = 16
);
  logic [8*NUM_SRC-1:0]      src_tdata_in;
  logic [NUM_SRC-1:0]        src_tvalid_in;
  logic [NUM_SRC-1:0]        src_tlast_in;
  logic [NUM_SRC-1:0]        src_tready_out;
  logic [PORT_W*NUM_SRC-1:0] src_port_in;
  logic [7:0]                udp_tdata_out;
  logic                      udp_tvalid_out;
  logic                      udp_tlast_out;
  logic                      udp_tready_in;
  logic [PORT_W-1:0]         dest_port_out;
  logic [NUM_SRC-1:0]        grant_out;
  logic                      busy_out;
  logic                      err_out;

  modport master (
    output src_tdata_in, src_tvalid_in, src_tlast_in,
    output src_port_in, udp_tready_in,
    input  src_tready_out, udp_tdata_out, udp_tvalid_out,
    input  udp_tlast_out, dest_port_out, grant_out,
    input  busy_out, err_out
  );

  modport slave (
    input  src_tdata_in, src_tvalid_in, src_tlast_in,
    input  src_port_in, udp_tready_in,
    output src_tready_out, udp_tdata_out, udp_tvalid_out,
    output udp_tlast_out, dest_port_out, grant_out,
    output busy_out, err_out
  );
endinterface

// File: rtl/udp_tx_arb.sv
// udp_tx_arb: packet-granular round-robin mux of NUM_SRC byte streams
// onto one UDP tx path; grant locked first byte..tlast, dest port latched.
// Ports: clk, reset (sync, active high), bus (udp_tx_arb_if.slave):
//   src_* per-source stream + port in, udp_* muxed stream out,
//   dest_port_out, grant_out (one-hot), busy_out, err_out.
// Option: UDP_TX_ARB_TIMEOUT_EN forces a 0x00/tlast byte after
//   TIMEOUT_CYC stalled cycles and pulses err_out; else err_out = 0.
`timescale 1ns/1ps
module udp_tx_arb #(
  parameter int NUM_SRC     = 4,
  parameter int PORT_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic          clk,
  input logic          reset,
  udp_tx_arb_if.slave  bus
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state, state_n;
  logic [IW-1:0]       ptr, ptr_n;
  logic [IW-1:0]       gidx, gidx_n;
  logic [IW-1:0]       req_idx, gnext;
  logic [IW:0]         scan;
  logic                req_found;
  logic [NUM_SRC-1:0]  grant, grant_n, rdy;
  logic [PORT_W-1:0]   dest, dest_n;
  logic [7:0]          sdata [NUM_SRC];
  logic [PORT_W-1:0]   sport [NUM_SRC];
  logic [7:0]          tdata;
  logic                tvalid, tlast;

`ifdef UDP_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          fire;
  logic          err, err_n;
`else
  logic          unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      sdata[i] = bus.src_tdata_in[8*i +: 8];
      sport[i] = bus.src_port_in[PORT_W*i +: PORT_W];
    end
  end

  // first requester at or after ptr, wrapping
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan = {1'b0, ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_SRC))
        scan = scan - (IW+1)'(NUM_SRC);
      if (!req_found && bus.src_tvalid_in[scan[IW-1:0]]) begin
        req_found = 1'b1;
        req_idx   = scan[IW-1:0];
      end
    end
  end

  assign gnext = (gidx == IW'(NUM_SRC - 1)) ? '0 : gidx + IW'(1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gidx_n  = gidx;
    grant_n = grant;
    dest_n  = dest;
    rdy     = '0;
    tdata   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
    cnt_n   = '0;
    err_n   = 1'b0;
    fire    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (req_found) begin
          state_n = XFER;
          gidx_n  = req_idx;
          grant_n = NUM_SRC'(1) << req_idx;
          dest_n  = sport[req_idx];
        end
      end
      XFER: begin
        tdata     = sdata[gidx];
        tvalid    = bus.src_tvalid_in[gidx];
        tlast     = bus.src_tlast_in[gidx];
        rdy[gidx] = bus.udp_tready_in;
`ifdef UDP_TX_ARB_TIMEOUT_EN
        fire = (cnt == CW'(TIMEOUT_CYC));
        // stalled source: close the packet with a filler byte
        if (fire) begin
          tdata  = 8'h00;
          tvalid = 1'b1;
          tlast  = 1'b1;
          rdy    = '0;
        end
        if (tvalid && bus.udp_tready_in)
          cnt_n = '0;
        else if (!fire)
          cnt_n = cnt + CW'(1);
        else
          cnt_n = cnt;
        err_n = fire && bus.udp_tready_in;
`endif
        if (tvalid && tlast && bus.udp_tready_in) begin
          state_n = IDLE;
          grant_n = '0;
          ptr_n   = gnext;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      grant <= '0;
      dest  <= '0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      cnt   <= '0;
      err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gidx  <= gidx_n;
      grant <= grant_n;
      dest  <= dest_n;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      cnt   <= cnt_n;
      err   <= err_n;
`endif
    end
  end

  assign bus.udp_tdata_out  = tdata;
  assign bus.udp_tvalid_out = tvalid;
  assign bus.udp_tlast_out  = tlast;
  assign bus.src_tready_out = rdy;
  assign bus.dest_port_out  = dest;
  assign bus.grant_out      = grant;
  assign bus.busy_out       = (state == XFER);
`ifdef UDP_TX_ARB_TIMEOUT_EN
  assign bus.err_out        = err;
`else
  assign bus.err_out        = 1'b0;
`endif
endmodule

// File: tb/tb_udp_tx_arb.sv
// tb_udp_tx_arb: scoreboard bench for udp_tx_arb.
// Source bytes queued per source; expected output order queued by hand.
`timescale 1ns/1ps
module tb_udp_tx_arb;
  localparam int NS = 4;
  localparam int PW = 16;
`ifdef UDP_TX_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  typedef struct {
    int         src;
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int          src;
    logic [7:0]  data;
    logic        last;
    logic [PW-1:0] port;
    logic        forced;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  udp_tx_arb_if #(.NUM_SRC(NS), .PORT_W(PW)) bus ();

  udp_tx_arb #(
    .NUM_SRC(NS), .PORT_W(PW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  beat_t pend[$];
  exp_t  sb[$];
  int    n_chk = 0;
  int    n_err = 0;
  logic  mon_en = 1'b0;
  logic  rdy_chk = 1'b1;
  logic  tr_toggle = 1'b0;
  logic  tr_level = 1'b1;
  logic  prev_last = 1'b0;
  logic  prev_forced = 1'b0;
  logic  mx;
  logic [PW-1:0] ports [NS];
  exp_t  me;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_srcs();
    logic [NS-1:0]    v, l;
    logic [8*NS-1:0]  d;
    logic [PW*NS-1:0] p;
    v = '0; l = '0; d = '0; p = '0;
    for (int i = 0; i < NS; i++) begin
      p[PW*i +: PW] = ports[i];
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k].src == i) begin
          v[i] = 1'b1;
          d[8*i +: 8] = pend[k].data;
          l[i] = pend[k].last;
          break;
        end
      end
    end
    bus.src_tvalid_in = v;
    bus.src_tlast_in  = l;
    bus.src_tdata_in  = d;
    bus.src_port_in   = p;
  endtask

  task automatic pop_src(input int s);
    for (int k = 0; k < pend.size(); k++) begin
      if (pend[k].src == s) begin
        pend.delete(k);
        break;
      end
    end
  endtask

  // source driver: bytes accepted at an edge leave the queue after it
  initial begin
    logic [NS-1:0] acc;
    int tc;
    tc = 0;
    for (int i = 0; i < NS; i++) ports[i] = '0;
    bus.udp_tready_in = 1'b1;
    drive_srcs();
    forever begin
      @(negedge clk);
      acc = bus.src_tvalid_in & bus.src_tready_out;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
        if (acc[i]) pop_src(i);
      if (tr_toggle) begin
        bus.udp_tready_in = (tc % 3 == 0);
        tc++;
      end else begin
        bus.udp_tready_in = tr_level;
        tc = 0;
      end
      drive_srcs();
    end
  end

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      prev_last   = 1'b0;
      prev_forced = 1'b0;
    end else begin
      if (rdy_chk)
        chk("ready_mirror", 32'(bus.src_tready_out),
            32'(bus.grant_out & {NS{bus.udp_tready_in}}));
      chk("err_pulse", 32'(bus.err_out), 32'(prev_forced));
      if (prev_last) begin
        chk("gap_busy", 32'(bus.busy_out), 32'(0));
        chk("gap_grant", 32'(bus.grant_out), 32'(0));
      end
      mx = bus.udp_tvalid_out && bus.udp_tready_in;
      prev_forced = 1'b0;
      if (mx) begin
        if (sb.size() == 0) begin
          chk("extra_byte", 32'(bus.udp_tvalid_out), 32'(0));
        end else begin
          me = sb.pop_front();
          chk("data", 32'(bus.udp_tdata_out), 32'(me.data));
          chk("last", 32'(bus.udp_tlast_out), 32'(me.last));
          chk("grant", 32'(bus.grant_out), 32'(1) << me.src);
          chk("dest_port", 32'(bus.dest_port_out), 32'(me.port));
          prev_forced = me.forced;
        end
      end
      prev_last = mx && bus.udp_tlast_out;
    end
  end

  task automatic load(input int s, input int n, input logic [7:0] base,
                      input logic with_last);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.src  = s;
      b.data = 8'(int'(base) + k);
      b.last = with_last && (k == n - 1);
      pend.push_back(b);
    end
  endtask

  task automatic expect_pkt(input int s, input int n, input logic [7:0] base,
                            input logic with_last);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.src    = s;
      e.data   = 8'(int'(base) + k);
      e.last   = with_last && (k == n - 1);
      e.port   = ports[s];
      e.forced = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    int c;
    c = 0;
    while (sb.size() > 0 && c < bound) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk(tag, 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pend.delete();
    sb.delete();
    tr_toggle = 1'b0;
    tr_level = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus.grant_out), 32'(0));
    chk("rst_busy", 32'(bus.busy_out), 32'(0));
    chk("rst_dest", 32'(bus.dest_port_out), 32'(0));
    chk("rst_err", 32'(bus.err_out), 32'(0));
    chk("rst_ready", 32'(bus.src_tready_out), 32'(0));
    chk("rst_tvalid", 32'(bus.udp_tvalid_out), 32'(0));
    chk("rst_tlast", 32'(bus.udp_tlast_out), 32'(0));
    chk("rst_tdata", 32'(bus.udp_tdata_out), 32'(0));
    reset = 1'b0;
    mon_en = 1'b1;

    // single source, latency and port latch
    ports[0] = 16'h1F90;
    @(negedge clk);
    load(0, 5, 8'h01, 1'b1);
    expect_pkt(0, 5, 8'h01, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("lat_not_yet", 32'(bus.grant_out), 32'(0));
    @(negedge clk);
    chk("lat_grant", 32'(bus.grant_out), 32'h1);
    chk("lat_busy", 32'(bus.busy_out), 32'(1));
    chk("lat_dest", 32'(bus.dest_port_out), 32'h1F90);
    wait_done("t1_done", 50);
    repeat (3) @(negedge clk);
    chk("dest_hold", 32'(bus.dest_port_out), 32'h1F90);
    chk("idle_busy", 32'(bus.busy_out), 32'(0));

    // all four requesting: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NS; i++) ports[i] = 16'(16'h1000 + i);
    for (int i = 0; i < NS; i++) load(i, 3, 8'(16 * i + 1), 1'b1);
    load(0, 3, 8'h81, 1'b1);
    for (int i = 0; i < NS; i++) expect_pkt(i, 3, 8'(16 * i + 1), 1'b1);
    expect_pkt(0, 3, 8'h81, 1'b1);
    wait_done("t2_done", 100);
    repeat (2) @(negedge clk);

    // backpressure pattern on source 2
    do_reset();
    ports[2] = 16'h0C02;
    tr_toggle = 1'b1;
    load(2, 4, 8'hC0, 1'b1);
    expect_pkt(2, 4, 8'hC0, 1'b1);
    wait_done("t3_done", 100);
    tr_toggle = 1'b0;
    repeat (3) @(negedge clk);

    // reset mid-packet; pointer was 3, must come back as 0
    ports[2] = 16'h2222;
    load(2, 8, 8'h50, 1'b1);
    expect_pkt(2, 2, 8'h50, 1'b1);
    sb[1].last = 1'b0;
    wait_done("t4_two", 50);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    pend.delete();
    @(negedge clk);
    chk("mid_rst_grant", 32'(bus.grant_out), 32'(0));
    chk("mid_rst_busy", 32'(bus.busy_out), 32'(0));
    chk("mid_rst_tvalid", 32'(bus.udp_tvalid_out), 32'(0));
    chk("mid_rst_ready", 32'(bus.src_tready_out), 32'(0));
    reset = 1'b0;
    ports[1] = 16'h1111;
    ports[3] = 16'h3333;
    load(3, 2, 8'h30, 1'b1);
    load(1, 2, 8'h60, 1'b1);
    expect_pkt(1, 2, 8'h60, 1'b1);
    expect_pkt(3, 2, 8'h30, 1'b1);
    wait_done("t4_done", 50);
    repeat (2) @(negedge clk);

    // one-byte packet, then search restarts at source 0
    do_reset();
    ports[1] = 16'h0111;
    ports[3] = 16'h0333;
    load(3, 1, 8'hEE, 1'b1);
    expect_pkt(3, 1, 8'hEE, 1'b1);
    wait_done("t5_one", 30);
    repeat (2) @(negedge clk);
    chk("t5_release", 32'(bus.grant_out), 32'(0));
    load(3, 1, 8'h33, 1'b1);
    load(1, 1, 8'h11, 1'b1);
    expect_pkt(1, 1, 8'h11, 1'b1);
    expect_pkt(3, 1, 8'h33, 1'b1);
    wait_done("t5_done", 30);
    repeat (2) @(negedge clk);

`ifdef UDP_TX_ARB_TIMEOUT_EN
    // stalled source 1 is closed with a filler byte; source 2 follows
    do_reset();
    rdy_chk = 1'b0;
    ports[1] = 16'hA001;
    ports[2] = 16'hA002;
    load(1, 3, 8'h71, 1'b0);
    load(2, 2, 8'h91, 1'b1);
    expect_pkt(1, 3, 8'h71, 1'b0);
    me.src = 1; me.data = 8'h00; me.last = 1'b1;
    me.port = 16'hA001; me.forced = 1'b1;
    sb.push_back(me);
    expect_pkt(2, 2, 8'h91, 1'b1);
    wait_done("t6_done", 200);
    repeat (3) @(negedge clk);
    rdy_chk = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
